// File: rtl/pixel_framebuffer_pkg.sv
// Shared raymarcher framebuffer types and default geometry.
// Imported by the framebuffer, its write interface and the ray cores.
package pixel_framebuffer_pkg;

  localparam int CORDW   = 10;
  localparam int COLOR_W = 11;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  typedef logic [COLOR_W-1:0] color_t;

  typedef struct packed {
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    color_t           color;
  } pixel_wr_t;

  function automatic logic in_range(input int x, input int y, input int h, input int v);
    return (x < h) && (y < v);
  endfunction

endpackage

// File: rtl/pixel_framebuffer_if.sv
// Pixel write channel from the ray cores into the framebuffer.
// drain_hold lets the producer side freeze the framebuffer drain (backpressure hook).
interface pixel_framebuffer_if #(
  parameter int CORDW   = pixel_framebuffer_pkg::CORDW,
  parameter int COLOR_W = pixel_framebuffer_pkg::COLOR_W
);
  import pixel_framebuffer_pkg::*;

  logic               wr_valid;
  logic               wr_ready;
  logic [CORDW-1:0]   wr_x;
  logic [CORDW-1:0]   wr_y;
  logic [COLOR_W-1:0] wr_color;
  logic               drain_hold;

  modport master (
    output wr_valid, wr_x, wr_y, wr_color, drain_hold,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_color, drain_hold,
    output wr_ready
  );

endinterface

// File: rtl/pixel_framebuffer_sync_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; ready is registered (not full).
// Reused on the core-to-framebuffer pixel paths.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  import pixel_framebuffer_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_n, rd_ptr_n;
  logic             do_push, do_pop;

  function automatic logic is_full(input logic [AW:0] w, input logic [AW:0] r);
    return (w ^ r) == {1'b1, {AW{1'b0}}};
  endfunction

  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && ready;
  assign do_pop   = pop && !empty;
  assign wr_ptr_n = wr_ptr + (AW+1)'(do_push);
  assign rd_ptr_n = rd_ptr + (AW+1)'(do_pop);
  assign dout     = store[rd_ptr[AW-1:0]];

  // ready looks at next-state pointers so a full FIFO drops ready on the filling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ready  <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      ready  <= !is_full(wr_ptr_n, rd_ptr_n);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_framebuffer.sv
// Raymarcher framebuffer: FIFO-buffered pixel writes into a colour RAM,
// fixed 2-cycle scanout reads, frame-complete pulse and saturating drop counter.
module pixel_framebuffer #(
  parameter int H_RES      = pixel_framebuffer_pkg::H_RES,
  parameter int V_RES      = pixel_framebuffer_pkg::V_RES,
  parameter int CORDW      = pixel_framebuffer_pkg::CORDW,
  parameter int COLOR_W    = pixel_framebuffer_pkg::COLOR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  pixel_framebuffer_if.slave   wr,
  input  logic [CORDW-1:0]     read_pixel_x,
  input  logic [CORDW-1:0]     read_pixel_y,
  output logic [COLOR_W-1:0]   o_color,
  output logic                 frame_done,
  output logic [15:0]          drop_count
);
  import pixel_framebuffer_pkg::*;

  localparam int FRAME_PIX = H_RES * V_RES;
  localparam int ADDR_W    = $clog2(FRAME_PIX);
  localparam int ENTRY_W   = 2 * CORDW + COLOR_W;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [CORDW-1:0] x,
                                                 input logic [CORDW-1:0] y);
    if (H_RES == 640)
      return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
    else
      return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] d);
    return (d == 16'hFFFF) ? d : d + 16'd1;
  endfunction

  logic [ENTRY_W-1:0] fifo_dout;
  logic [CORDW-1:0]   fifo_x, fifo_y;
  logic [COLOR_W-1:0] fifo_c;
  logic               fifo_empty, pop;

  sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (wr.wr_valid),
    .din   ({wr.wr_x, wr.wr_y, wr.wr_color}),
    .ready (wr.wr_ready),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign {fifo_x, fifo_y, fifo_c} = fifo_dout;
  assign pop = !fifo_empty && !wr.drain_hold;

  // Stage p0: popped pixel and its in-range flag
  logic               vld_p0, inr_p0;
  logic [CORDW-1:0]   x_p0, y_p0;
  logic [COLOR_W-1:0] color_p0;
  logic [ADDR_W-1:0]  wr_addr_p0;

  always_ff @(posedge clk) begin
    if (pop) begin
      x_p0     <= fifo_x;
      y_p0     <= fifo_y;
      color_p0 <= fifo_c;
      inr_p0   <= in_range(32'(fifo_x), 32'(fifo_y), H_RES, V_RES);
    end
  end

  assign wr_addr_p0 = pix_addr(x_p0, y_p0);

  // Read stage p0: scanout address; p1: registered RAM output
  logic [ADDR_W-1:0]  rd_addr_p0;
  logic               rd_inr_p0, rd_inr_p1;
  logic [COLOR_W-1:0] rd_data_p1;
  logic [COLOR_W-1:0] mem [FRAME_PIX];

  always_ff @(posedge clk) begin
    rd_addr_p0 <= pix_addr(read_pixel_x, read_pixel_y);
  end

  // Single block keeps read-before-write ordering and RAM inference
  always_ff @(posedge clk) begin
    if (vld_p0 && inr_p0) mem[wr_addr_p0] <= color_p0;
    rd_data_p1 <= mem[rd_addr_p0];
  end

  assign o_color = rd_inr_p1 ? rd_data_p1 : '0;

  logic [ADDR_W-1:0] pix_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      rd_inr_p0  <= 1'b0;
      rd_inr_p1  <= 1'b0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
      drop_count <= '0;
    end else begin
      vld_p0     <= pop;
      rd_inr_p0  <= in_range(32'(read_pixel_x), 32'(read_pixel_y), H_RES, V_RES);
      rd_inr_p1  <= rd_inr_p0;
      frame_done <= 1'b0;
      if (vld_p0) begin
        if (inr_p0) begin
          if (pix_cnt == ADDR_W'(FRAME_PIX - 1)) begin
            pix_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            pix_cnt <= pix_cnt + ADDR_W'(1);
          end
        end else begin
          drop_count <= sat_inc(drop_count);
        end
      end
    end
  end

endmodule
